// File: rtl/console_rx_fifo.sv
// rtl/console_rx_fifo.sv - UART receive FIFO feeding the CPU read-char path (optional CONSOLE_RX_OVERFLOW_EN: drop-and-flag when full)
module console_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           uart_dat_do,
  output logic                  uart_dat_re,
  input  logic                  cpu_re,
  output logic [31:0]           cpu_dat,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  ovf_clr,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  byte_valid, full, empty, pop;
  logic                  can_take, drain, store;

  assign byte_valid = (uart_dat_do != 32'hFFFF_FFFF);
  assign full       = (count == CNT_FULL);
  assign empty      = (count == '0);
  assign pop        = cpu_re && !empty;
  // A same-cycle pop frees the slot the incoming byte needs.
  assign store      = drain && (!full || pop);

`ifdef CONSOLE_RX_OVERFLOW_EN
  logic drop;
  // Always drain so the UART never overruns; excess bytes are discarded here.
  assign can_take = 1'b1;
  assign drop     = drain && full && !pop;
`else
  logic unused_ovf_clr;
  // Leave the byte in the UART while full so it applies backpressure.
  assign can_take = !full || pop;
  assign unused_ovf_clr = ovf_clr;
  assign overflow = 1'b0;
`endif

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Drain FSM next state; ACK/SETTLE mask uart_dat_do while the UART clears its flag.
  always_comb begin
    next_state = state;
    drain      = 1'b0;
    case (state)
      IDLE: begin
        if (byte_valid && can_take) begin
          drain      = 1'b1;
          next_state = ACK;
        end
      end
      ACK:     next_state = SETTLE;
      SETTLE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered acknowledge pulse toward the UART, high exactly during ACK.
  always_ff @(posedge clk) begin
    if (!resetn) uart_dat_re <= 1'b0;
    else         uart_dat_re <= drain;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({store, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= uart_dat_do[7:0];
  end

`ifdef CONSOLE_RX_OVERFLOW_EN
  // Sticky drop flag; a new drop beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!resetn)      overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end
`endif

  // Non-blocking read semantics: zero when nothing is buffered.
  always_comb begin
    cpu_dat = 32'h0;
    if (!empty) cpu_dat = {24'h0, mem[rd_ptr]};
  end

endmodule

// File: doc/console_rx_fifo.md
# console_rx_fifo

Receive-side buffer between the `simpleuart` console and the CPU core. Whenever the UART holds a received byte, the block drains it into a small FIFO, so characters arriving between CPU polls are kept rather than overwritten. The CPU's read-char instruction then takes bytes from this FIFO instead of from the UART data register. Its read port returns a zero byte when the FIFO is empty, matching the existing non-blocking read semantics.

## Interface

Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16 by default), each 8 bits wide.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `uart_dat_do`  in  32  UART `reg_dat_do`.
  - Equal to 32'hFFFFFFFF when no byte is held.
  - Otherwise the received byte is in [7:0].
- `uart_dat_re`  out  1  one-cycle pulse to UART `reg_dat_re`, consuming the held byte.
- `cpu_re`  in  1  one-cycle pulse from the CPU that pops the head entry.
- `cpu_dat`  out  32  head byte zero-extended to 32 bits; 32'h0 when the FIFO is empty.
- `count`  out  DEPTH_LOG2+1  number of stored entries, 0..2^DEPTH_LOG2.
- `ovf_clr`  in  1  clears `overflow`; ignored when `CONSOLE_RX_OVERFLOW_EN` is undefined.
- `overflow`  out  1  sticky flag: a received byte was dropped.

## Operation

- **Storage:** register array of 2^DEPTH_LOG2 x 8 bits.
  - Read and write pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
  - `count` is tracked separately; full means `count == 2^DEPTH_LOG2`, empty means `count == 0`.
- **Byte valid:** `uart_dat_do != 32'hFFFFFFFF`.
- **Drain FSM**, states IDLE, ACK, SETTLE:
  - IDLE: a push is allowed when the byte is valid and the FIFO is not full. Under the macro, a push is also allowed when full (see Configuration).
    - On a push: write `uart_dat_do[7:0]` at the write pointer, register `uart_dat_re <= 1`, go to ACK.
    - Otherwise stay in IDLE.
  - ACK: `uart_dat_re` is high for this cycle only; `uart_dat_do` is ignored. Go to SETTLE.
  - SETTLE: `uart_dat_re` is low; `uart_dat_do` is ignored, because the UART clears its valid flag at the end of ACK. Go to IDLE.
- **Pop:** `cpu_re` while not empty advances the read pointer and decrements `count`. `cpu_re` while empty has no effect.
- **`cpu_dat`:** combinational from the head entry and the empty flag. It changes on the cycle after a pop or after the first push.
- **Simultaneous push and pop:** both take effect and `count` is unchanged. This includes the full case: the pop frees a slot, so the push is accepted and nothing is dropped.
- **Reset:** on the edge where `resetn` is sampled low, all of the following apply regardless of state, including mid-ACK:
  - state <= IDLE;
  - pointers, `count` <= 0;
  - `uart_dat_re` <= 0;
  - `overflow` <= 0.
- **Output reset values:** `uart_dat_re` 0, `cpu_dat` 0, `count` 0, `overflow` 0. Array contents are not reset.

## Timing

- The byte becomes valid in cycle N. It is written at the end of N, `uart_dat_re` is high in N+1, and `count` and `cpu_dat` reflect it in N+1.
- Minimum 3 cycles per drained byte, far below the character time at any supported baud rate.
- `cpu_re` sampled at the end of cycle M: new head visible on `cpu_dat` in M+1.
- Single-cycle path only; no multicycle constraints.

## Configuration

- Macro `CONSOLE_RX_OVERFLOW_EN`.
- **Defined:** when full, IDLE still drains a valid byte (normal ACK/SETTLE pulse).
  - With no same-cycle pop, the byte is discarded and `overflow` is set.
  - `ovf_clr` clears `overflow`; set wins over a same-cycle clear.
- **Undefined:** when full with no same-cycle pop, IDLE does not drain. The byte stays in the UART, which provides backpressure (later UART bytes may be overrun inside the UART). `overflow` is tied to 0 and `ovf_clr` is unused.

## Test plan

- **Single byte:** reset, drive `uart_dat_do` = 32'h41 until `uart_dat_re` pulses, then 32'hFFFFFFFF.
  - Exactly one `uart_dat_re` pulse.
  - `count` = 1, `cpu_dat` = 32'h41.
  - After `cpu_re`: `count` = 0, `cpu_dat` = 0.
- **Order and wrap:** push 20 bytes 0x00..0x13, popping after every 10 with DEPTH_LOG2 = 4. Popped sequence is 0x00..0x13 in order, with pointers wrapping past 15.
- **Fill (macro defined):** push 17 bytes with no pops.
  - `count` = 16, `overflow` = 1, head = first byte, 17th byte lost.
  - `ovf_clr` returns `overflow` to 0.
- **Fill (macro undefined):** push 17 bytes with no pops.
  - 16 `uart_dat_re` pulses; the 17th byte is held with no pulse.
  - After one `cpu_re`, the 17th byte is drained and `count` returns to 16.
- **Full plus concurrent pop:** at `count` = 16, a push and `cpu_re` occur in the same cycle. `count` stays 16, no drop, `overflow` stays 0.
- **Reset mid-ACK:** assert `resetn` = 0 during ACK.
  - Next cycle: `uart_dat_re` = 0, `count` = 0, `cpu_dat` = 0, FSM in IDLE.
  - `cpu_re` while empty leaves `count` at 0.
